// File: rtl/coffee_machine_controller_pkg.sv
// Shared definitions for the coffee machine controller.
// Holds the phase/state encoding (also the sel display code), drink codes,
// the price table, coin values and the credit cap.
package coffee_machine_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_SELECT  = 3'b001,
    ST_PAY     = 3'b010,
    ST_PUMP    = 3'b011,
    ST_HEAT    = 3'b100,
    ST_DELIVER = 3'b101,
    ST_ERROR   = 3'b110,
    ST_CHANGE  = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    DRK_ESPRESSO   = 2'b00,
    DRK_LEITE      = 2'b01,
    DRK_CAMOMILA   = 2'b10,
    DRK_CAPPUCCINO = 2'b11
  } drink_t;

  localparam logic [4:0] PRICE_ESPRESSO   = 5'd4;
  localparam logic [4:0] PRICE_LEITE      = 5'd5;
  localparam logic [4:0] PRICE_CAMOMILA   = 5'd6;
  localparam logic [4:0] PRICE_CAPPUCCINO = 5'd7;

  localparam logic [4:0] COIN2_VAL  = 5'd2;
  localparam logic [4:0] COIN5_VAL  = 5'd5;
  localparam logic [4:0] CREDIT_CAP = 5'd10;

  function automatic logic [4:0] drink_price(input drink_t d);
    case (d)
      DRK_ESPRESSO:   drink_price = PRICE_ESPRESSO;
      DRK_LEITE:      drink_price = PRICE_LEITE;
      DRK_CAMOMILA:   drink_price = PRICE_CAMOMILA;
      default:        drink_price = PRICE_CAPPUCCINO;
    endcase
  endfunction

endpackage

// File: rtl/coffee_machine_controller_phase_timer.sv
// Phase timer: down-counter loaded on phase entry.
// Ports: clk, rst_n (async active-low), load (strobe), load_val (phase
// length in cycles), done (high during the last cycle of the phase, i.e.
// while the count equals 1).
module phase_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign done = (cnt == TW'(1));

endmodule

// File: rtl/coffee_machine_controller.sv
// Coffee machine controller: drink selection, coin credit handling,
// timed dispense phases (pump, heat, deliver) and change return.
// Ports: clk, rst_n (async active-low); button pulses start/next/confirm/
// cancel; coin pulses coin2/coin5; note_bad; sensor[2:0] (water, capsule,
// cup missing). Outputs: sel (phase code = state register), bebida, soma
// (credit or change), valoramais, cedulaINV, and the actuator enables.
module coffee_machine_controller
  import coffee_machine_controller_pkg::*;
#(
  parameter int T_PUMP    = 50,
  parameter int T_HEAT    = 80,
  parameter int T_DELIVER = 30,
  parameter int T_CHANGE  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       next,
  input  logic       confirm,
  input  logic       cancel,
  input  logic       coin2,
  input  logic       coin5,
  input  logic       note_bad,
  input  logic [2:0] sensor,
  output logic [2:0] sel,
  output logic [1:0] bebida,
  output logic [4:0] soma,
  output logic       valoramais,
  output logic       cedulaINV,
  output logic       pump_en,
  output logic       heat_en,
  output logic       deliver_en,
  output logic       change_en
);

  state_t      state_q, state_nxt;
  drink_t      drink_q, drink_nxt;
  logic [4:0]  soma_q, soma_nxt;
  logic        vmais_q, vmais_nxt;
  logic        cinv_q, cinv_nxt;
  logic [5:0]  coin_v, coin_sum;
  logic [4:0]  price;
  logic        tmr_load, tmr_done;
  logic [15:0] tmr_val;

  phase_timer #(.TW(16)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drink_q <= DRK_ESPRESSO;
      soma_q  <= '0;
      vmais_q <= 1'b0;
      cinv_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      drink_q <= drink_nxt;
      soma_q  <= soma_nxt;
      vmais_q <= vmais_nxt;
      cinv_q  <= cinv_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    drink_nxt = drink_q;
    soma_nxt  = soma_q;
    vmais_nxt = vmais_q;
    cinv_nxt  = cinv_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    coin_v    = (coin2 ? {1'b0, COIN2_VAL} : 6'd0) + (coin5 ? {1'b0, COIN5_VAL} : 6'd0);
    coin_sum  = {1'b0, soma_q} + coin_v;
    price     = drink_price(drink_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SELECT;
          drink_nxt = DRK_ESPRESSO;
        end
      end
      ST_SELECT: begin
        if (cancel)       state_nxt = ST_IDLE;
        else if (confirm) state_nxt = ST_PAY;
        else if (next)    drink_nxt = drink_t'(drink_q + 2'd1);
      end
      ST_PAY: begin
        // Cancel beats coins/confirm; a successful confirm ignores a
        // same-cycle coin so credit is never both added and charged.
        if (cancel) begin
          state_nxt = (soma_q == '0) ? ST_IDLE : ST_CHANGE;
        end else if (confirm && (soma_q >= price)) begin
          if (sensor != 3'b000) begin
            state_nxt = ST_ERROR;
          end else begin
            state_nxt = ST_PUMP;
            soma_nxt  = soma_q - price;
          end
        end else begin
          if (coin_v != 6'd0) begin
            if (coin_sum <= {1'b0, CREDIT_CAP}) begin
              soma_nxt  = coin_sum[4:0];
              vmais_nxt = 1'b0;
              cinv_nxt  = 1'b0;
            end else begin
              vmais_nxt = 1'b1;
            end
          end
          if (note_bad) cinv_nxt = 1'b1;
        end
        // Both warning flags only live inside PAY.
        if (state_nxt != ST_PAY) begin
          vmais_nxt = 1'b0;
          cinv_nxt  = 1'b0;
        end
      end
      ST_ERROR: begin
        if (cancel) begin
          state_nxt = ST_CHANGE;
        end else if (sensor == 3'b000) begin
          state_nxt = ST_PUMP;
          soma_nxt  = soma_q - price;
        end
      end
      ST_PUMP:    if (tmr_done) state_nxt = ST_HEAT;
      ST_HEAT:    if (tmr_done) state_nxt = ST_DELIVER;
      ST_DELIVER: if (tmr_done) state_nxt = (soma_q != '0) ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: begin
        if (tmr_done) begin
          state_nxt = ST_IDLE;
          soma_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Load the timer on entry into any timed phase.
    if (state_nxt != state_q) begin
      case (state_nxt)
        ST_PUMP:    begin tmr_load = 1'b1; tmr_val = 16'(T_PUMP);    end
        ST_HEAT:    begin tmr_load = 1'b1; tmr_val = 16'(T_HEAT);    end
        ST_DELIVER: begin tmr_load = 1'b1; tmr_val = 16'(T_DELIVER); end
        ST_CHANGE:  begin tmr_load = 1'b1; tmr_val = 16'(T_CHANGE);  end
        default:    begin tmr_load = 1'b0; tmr_val = '0;             end
      endcase
    end
  end

  assign sel        = state_q;
  assign bebida     = drink_q;
  assign soma       = soma_q;
  assign valoramais = vmais_q;
  assign cedulaINV  = cinv_q;
  assign pump_en    = (state_q == ST_PUMP);
  assign heat_en    = (state_q == ST_HEAT);
  assign deliver_en = (state_q == ST_DELIVER);
  assign change_en  = (state_q == ST_CHANGE);

endmodule
